// File: rtl/mdu_unit.sv
// mdu_unit -- multi-cycle multiply/divide unit with HI/LO register pair.
//
// Sits beside the ALU in the EX stage. The pipeline stalls while busy is high.
// Operands are captured when start is accepted. HI/LO are written only when
// the operation completes, or directly by mthi/mtlo.
//
// Parameters:
//   WIDTH      operand and HI/LO width (>= 8)
//   MUL_CYCLES busy cycles for a multiply (>= 1)
//   DIV_CYCLES busy cycles for a divide (>= 1)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   op request, one-cycle pulse
//   md_op  in   [3:0] operation:
//                 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//                 6 madd, 7 maddu, 8 msub, 9 msubu; other codes are reserved
//   A1     in   [WIDTH-1:0] rs operand / dividend / mthi-mtlo data
//   A2     in   [WIDTH-1:0] rt operand / divisor
//   flush  in   abort the in-flight op
//   busy   out  an op is in flight
//   done   out  one-cycle pulse in the cycle HI/LO take a mul/div result
//   hi     out  [WIDTH-1:0] HI register
//   lo     out  [WIDTH-1:0] LO register
//
// Configuration macro:
//   MDU_MADD_EN  enables madd/maddu/msub/msubu (accumulate into {hi,lo}).
//                Without it, those codes are reserved and ignored.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } md_op_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  // Request decode
  logic w_is_mul;
  logic w_is_div;
  logic w_is_mthi;
  logic w_is_mtlo;

  always_comb begin
    w_is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
    w_is_mul  = w_is_mul || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
    w_is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
    w_is_mthi = (md_op == OP_MTHI);
    w_is_mtlo = (md_op == OP_MTLO);
  end

  // Multiply: both operands are extended to 2*WIDTH so one unsigned
  // multiplier yields the exact signed or unsigned full-width product.
  logic                   w_msigned;
  logic [2*WIDTH-1:0]     w_ea;
  logic [2*WIDTH-1:0]     w_eb;
  logic [2*WIDTH-1:0]     w_prod;
  logic [2*WIDTH-1:0]     w_mul_res;

  always_comb begin
    w_msigned = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
    w_ea      = w_msigned ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_eb      = w_msigned ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod    = w_ea * w_eb;
    w_mul_res = w_prod;
`ifdef MDU_MADD_EN
    // Accumulates against HI/LO as they stand at completion.
    if ((r_op == OP_MADD) || (r_op == OP_MADDU))
      w_mul_res = {r_hi, r_lo} + w_prod;
    else if ((r_op == OP_MSUB) || (r_op == OP_MSUBU))
      w_mul_res = {r_hi, r_lo} - w_prod;
`endif
  end

  // Divide: signed case is done on magnitudes, then signs are restored
  // (quotient toward zero, remainder takes the dividend's sign). MIN/-1
  // falls out naturally as quotient MIN, remainder 0.
  logic             w_na;
  logic             w_nb;
  logic [WIDTH-1:0] w_ua;
  logic [WIDTH-1:0] w_ub;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  always_comb begin
    w_na = (r_op == OP_DIV) && r_a[WIDTH-1];
    w_nb = (r_op == OP_DIV) && r_b[WIDTH-1];
    w_ua = w_na ? -r_a : r_a;
    w_ub = w_nb ? -r_b : r_b;
    w_uq = '0;
    w_ur = '0;
    if (w_ub != '0) begin
      w_uq = w_ua / w_ub;
      w_ur = w_ua % w_ub;
    end
    if (r_b == '0) begin
      w_q = '1;
      w_r = r_a;
    end else begin
      w_q = (w_na ^ w_nb) ? -w_uq : w_uq;
      w_r = w_na ? -w_ur : w_ur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (w_is_mul || w_is_div) begin
              r_state <= w_is_mul ? S_MUL : S_DIV;
              r_cnt   <= w_is_mul ? MUL_CNT : DIV_CNT;
              r_op    <= md_op;
              r_a     <= A1;
              r_b     <= A2;
            end else if (w_is_mthi) begin
              r_hi <= A1;
            end else if (w_is_mtlo) begin
              r_lo <= A1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            if (r_state == S_MUL) begin
              r_hi <= w_mul_res[2*WIDTH-1:WIDTH];
              r_lo <= w_mul_res[WIDTH-1:0];
            end else begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit -- self-checking bench for mdu_unit (WIDTH=32, default latencies).
// Expected HI/LO values and latencies come from a behavioural model using
// plain 64-bit / int arithmetic on the architectural op definitions.
module tb_mdu_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A1;
  logic [31:0] A2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_unit #(
    .WIDTH     (32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .md_op(md_op),
    .A1   (A1),
    .A2   (A2),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural reference: returns new HI/LO, busy latency and whether done pulses.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] eh, inout logic [31:0] el,
                        output int lat, output bit dn);
    longint      sp;
    logic [63:0] up;
    logic [63:0] acc;
    int          sa;
    int          sb;
    sa  = a;
    sb  = b;
    lat = 0;
    dn  = 1'b0;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: begin {eh, el} = sp; lat = 5; dn = 1'b1; end
      4'd1: begin {eh, el} = up; lat = 5; dn = 1'b1; end
      4'd2: begin
        lat = 10; dn = 1'b1;
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = 32'h8000_0000; eh = 32'd0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      4'd3: begin
        lat = 10; dn = 1'b1;
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      4'd4: eh = a;
      4'd5: el = a;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: begin
        acc = {eh, el};
        if (op == 4'd6)      acc = acc + sp;
        else if (op == 4'd7) acc = acc + up;
        else if (op == 4'd8) acc = acc - sp;
        else                 acc = acc - up;
        {eh, el} = acc;
        lat = 5; dn = 1'b1;
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion and compare against the model.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
    bit          dn;
    int          n;
    bit          stable;
    eh = m_hi;
    el = m_lo;
    ref_op(op, a, b, eh, el, lat, dn);
    @(negedge clk);
    start = 1'b1; md_op = op; A1 = a; A2 = b;
    @(negedge clk);
    start = 1'b0; md_op = 4'($urandom); A1 = $urandom; A2 = $urandom;
    n = 0;
    stable = 1'b1;
    while (busy && n < 40) begin
      if (done || hi !== m_hi || lo !== m_lo) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(lat));
    check({tag, " stable_while_busy"}, 64'(stable), 64'd1);
    check({tag, " done"}, 64'(done), 64'(dn));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({tag, " done_cleared"}, 64'(done), 64'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: rnd_val = 32'd0;
      1: rnd_val = 32'd1;
      2: rnd_val = 32'hFFFF_FFFF;
      3: rnd_val = 32'h8000_0000;
      4: rnd_val = 32'h7FFF_FFFF;
      5: rnd_val = 32'($urandom_range(0, 20)) - 32'd10;
      default: rnd_val = $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; md_op = '0; A1 = '0; A2 = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply / divide examples with known constants
    run_op("mult -2*3", 4'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult -2*3 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult -2*3 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    run_op("multu", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("multu hi const", 64'(hi), 64'h2);
    run_op("div -7/2", 4'd2, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div -7/2 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op("divu 7/0", 4'd3, 32'd7, 32'd0);
    check("divu 7/0 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("divu 7/0 hi const", 64'(hi), 64'h7);
    run_op("div -7/0", 4'd2, 32'hFFFF_FFF9, 32'd0);
    run_op("div MIN/-1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div MIN/-1 lo const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op("mthi", 4'd4, 32'h1234_5678, 32'd0);
    check("mthi hi const", 64'(hi), 64'h1234_5678);
    run_op("mtlo", 4'd5, 32'hCAFE_F00D, 32'd0);
    run_op("reserved", 4'd12, 32'h5555_5555, 32'h1);

    // Accumulate boundary: {0, FFFF_FFFF} + 1*1 carries into HI
    run_op("set hi", 4'd4, 32'd0, 32'd0);
    run_op("set lo", 4'd5, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu 1*1", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu carry hi const", 64'(hi), 64'h1);
    check("maddu carry lo const", 64'(lo), 64'h0);
`else
    check("maddu ignored hi const", 64'(hi), 64'h0);
    check("maddu ignored lo const", 64'(lo), 64'h0000_0000_FFFF_FFFF);
`endif

    // Flush on the 3rd busy cycle of a divide
    @(negedge clk);
    start = 1'b1; md_op = 4'd2; A1 = 32'd100; A2 = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("flush no done", 64'(dones), 64'd0);
    check("flush hi", 64'(hi), 64'(m_hi));
    check("flush lo", 64'(lo), 64'(m_lo));

    // flush together with start in IDLE: start ignored
    start = 1'b1; flush = 1'b1; md_op = 4'd4; A1 = 32'hABCD_0000;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    check("flush+start hi", 64'(hi), 64'(m_hi));

    // Start while busy is ignored
    start = 1'b1; md_op = 4'd1; A1 = 32'd3; A2 = 32'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; md_op = 4'd4; A1 = 32'hDEAD_BEEF;
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("busy start done count", 64'(dones), 64'd1);
    check("busy start hi", 64'(hi), 64'd0);
    check("busy start lo", 64'(lo), 64'd12);
    m_hi = 32'd0; m_lo = 32'd12;

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d op%0d", i, op), op, rnd_val(), rnd_val());
    end

    // Asynchronous reset in the middle of a divide
    run_op("pre-reset mthi", 4'd4, 32'h1111_2222, 32'd0);
    @(negedge clk);
    start = 1'b1; md_op = 4'd2; A1 = 32'd50; A2 = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op("post-reset mult", 4'd0, 32'd7, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
